// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // All flags decode from the registered count, so they never glitch on input activity.
    assign count        = r_count;
    assign full         = (r_count == DEPTH_C);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr_en && !full;
    assign w_rd_acc = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A rejection in the same cycle as err_clr keeps the flag set.
            if (wr_en && full)
                r_overflow <= 1'b1;
            else if (err_clr)
                r_overflow <= 1'b0;
            if (rd_en && empty)
                r_underflow <= 1'b1;
            else if (err_clr)
                r_underflow <= 1'b0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign rd_valid = !empty;
`else
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc)
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomized and directed bench for sync_fifo_flags against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en, rd_en, err_clr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0]    count;

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO contents are just a queue.
    logic [WIDTH-1:0] q[$];
    bit               m_ovf, m_udf, m_valid;
    logic [WIDTH-1:0] m_data;

    sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic chk_all();
        int n;
        n = q.size();
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == DEPTH));
        chk("almost_full", int'(almost_full), int'(n >= AF));
        chk("almost_empty", int'(almost_empty), int'(n <= AE));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("rd_valid", int'(rd_valid), int'(n != 0));
        if (n != 0) chk("rd_data", int'(rd_data), int'(q[0]));
`else
        chk("rd_valid", int'(rd_valid), int'(m_valid));
        chk("rd_data", int'(rd_data), int'(m_data));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check just after.
    task automatic cycle(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
        bit was_full, was_empty;
        wr_en = w; wr_data = d; rd_en = r; err_clr = c;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        m_valid = 1'b0;
        if (r && !was_empty) begin
            m_data  = q.pop_front();
            m_valid = 1'b1;
        end
        if (w && !was_full) q.push_back(d);
        if (w && was_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && was_empty) m_udf = 1'b1; else if (c) m_udf = 1'b0;
        #1;
        chk_all();
        wr_en = 0; rd_en = 0; err_clr = 0;
    endtask

    // Asynchronous reset applied away from the clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        q.delete();
        m_ovf = 0; m_udf = 0; m_valid = 0; m_data = '0;
        chk_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        wr_en = 0; rd_en = 0; err_clr = 0; wr_data = '0;
        rst = 1'b1;
        #1;
        q.delete(); m_ovf = 0; m_udf = 0; m_valid = 0; m_data = '0;
        chk_all();
        @(negedge clk);
        rst = 1'b0;

        // Fill past full, then drain past empty.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1, 8'(i), 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);

        // Simultaneous requests at full and at empty.
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h80 + i), 0, 0);
        cycle(1, 8'hAA, 1, 0);
        for (int i = 0; i < DEPTH - 1; i++) cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h55, 1, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);

        // Both flags set; clear them, then clear concurrent with a rejected write.
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i * 3), 0, 0);
        cycle(1, 8'hEE, 0, 1);
        cycle(0, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);

        // Wrap rounds of 10 in / 10 out.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) cycle(1, 8'($urandom), 0, 0);
            for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1, 0);
        end

        // Read latency on a single word.
        cycle(1, 8'h3C, 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);

        // Reset mid-stream with five entries held.
        for (int i = 0; i < 5; i++) cycle(1, 8'(i + 1), 0, 0);
        do_reset();

        // Random phases biased toward filling, draining and balanced traffic.
        for (int ph = 0; ph < 12; ph++) begin
            int pw;
            pw = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 15 : 50;
            for (int i = 0; i < 120; i++) begin
                v = 8'($urandom);
                cycle($urandom_range(0, 99) < pw, v,
                      $urandom_range(0, 99) < (100 - pw), $urandom_range(0, 15) == 0);
            end
            if (ph == 7) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
